// File: rtl/ssit_clr_ctrl.sv
// Periodic SSIT/LFST clear sequencer: counts retirements, stalls rename, walks both tables.
// Optional statistics outputs are enabled by defining SSIT_CLR_STAT_EN.
module ssit_clr_ctrl #(
    parameter int unsigned SSIT_IDX_W   = 10,
    parameter int unsigned LFST_IDX_W   = 7,
    parameter int unsigned CNT_W        = 20,
    parameter int unsigned CLR_INTERVAL = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            retire_cnt_i,
    input  logic                  force_clr_i,
    input  logic                  clr_gnt_i,
    output logic                  clr_req_o,
    output logic                  ssit_clr_we_o,
    output logic [SSIT_IDX_W-1:0] ssit_clr_idx_o,
    output logic                  lfst_clr_we_o,
    output logic [LFST_IDX_W-1:0] lfst_clr_idx_o,
    output logic                  busy_o,
    output logic                  clr_done_o
`ifdef SSIT_CLR_STAT_EN
    ,
    output logic [15:0]           clr_count_o,
    output logic [0:0]            force_seen_o
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, WALK, DONE} state_t;

    localparam logic [CNT_W:0]      INTERVAL = (CNT_W+1)'(CLR_INTERVAL);
    localparam logic [SSIT_IDX_W:0] LAST_IDX = (SSIT_IDX_W+1)'((1 << SSIT_IDX_W) - 1);
    localparam logic [SSIT_IDX_W:0] LFST_N   = (SSIT_IDX_W+1)'(1 << LFST_IDX_W);

    state_t               state;
    logic [CNT_W-1:0]     interval_cnt;
    logic [SSIT_IDX_W:0]  walk_idx;

    logic [CNT_W:0]       cnt_sum;
    logic [CNT_W-1:0]     cnt_sat;
    logic                 trigger;
    logic [SSIT_IDX_W:0]  walk_nxt;
    logic                 lfst_hit;

    always_comb begin
        cnt_sum  = (CNT_W+1)'(interval_cnt) + (CNT_W+1)'(retire_cnt_i);
        cnt_sat  = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
        // Unsaturated sum keeps the threshold exact even when the counter would clip.
        trigger  = force_clr_i || (cnt_sum >= INTERVAL);
        walk_nxt = walk_idx + (SSIT_IDX_W+1)'(1);
        lfst_hit = walk_nxt < LFST_N;
    end

`ifdef SSIT_CLR_STAT_EN
    logic forced;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            interval_cnt   <= '0;
            walk_idx       <= '0;
            clr_req_o      <= 1'b0;
            ssit_clr_we_o  <= 1'b0;
            ssit_clr_idx_o <= '0;
            lfst_clr_we_o  <= 1'b0;
            lfst_clr_idx_o <= '0;
            busy_o         <= 1'b0;
            clr_done_o     <= 1'b0;
`ifdef SSIT_CLR_STAT_EN
            clr_count_o    <= '0;
            force_seen_o   <= '0;
            forced         <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    interval_cnt <= cnt_sat;
                    if (trigger) begin
                        state     <= REQ;
                        clr_req_o <= 1'b1;
                        busy_o    <= 1'b1;
`ifdef SSIT_CLR_STAT_EN
                        forced    <= force_clr_i;
`endif
                    end
                end
                REQ: begin
                    if (clr_gnt_i) begin
                        state          <= WALK;
                        interval_cnt   <= '0;
                        walk_idx       <= '0;
                        ssit_clr_we_o  <= 1'b1;
                        ssit_clr_idx_o <= '0;
                        lfst_clr_we_o  <= 1'b1;
                        lfst_clr_idx_o <= '0;
                    end
                end
                WALK: begin
                    if (walk_idx == LAST_IDX) begin
                        state          <= DONE;
                        clr_req_o      <= 1'b0;
                        ssit_clr_we_o  <= 1'b0;
                        ssit_clr_idx_o <= '0;
                        lfst_clr_we_o  <= 1'b0;
                        lfst_clr_idx_o <= '0;
                        clr_done_o     <= 1'b1;
`ifdef SSIT_CLR_STAT_EN
                        if (clr_count_o != '1)
                            clr_count_o <= clr_count_o + 16'd1;
                        force_seen_o   <= forced;
`endif
                    end else begin
                        walk_idx       <= walk_nxt;
                        ssit_clr_idx_o <= walk_nxt[SSIT_IDX_W-1:0];
                        lfst_clr_we_o  <= lfst_hit;
                        lfst_clr_idx_o <= lfst_hit ? walk_nxt[LFST_IDX_W-1:0] : '0;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    busy_o     <= 1'b0;
                    clr_done_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ssit_clr_ctrl.sv
// Directed bench for ssit_clr_ctrl: vector table for the basic clear plus hand-written corner sequences.
module tb_ssit_clr_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] retire_cnt;
    logic       force_clr;
    logic       clr_gnt;
    logic       clr_req, ssit_we, lfst_we, busy, done;
    logic [3:0] ssit_idx;
    logic [2:0] lfst_idx;

    logic [2:0] retire2;
    logic       force2, gnt2;
    logic       req2, swe2, lwe2, busy2, done2;
    logic [3:0] sidx2;
    logic [2:0] lidx2;

`ifdef SSIT_CLR_STAT_EN
    logic [15:0] clr_count, clr_count2;
    logic [0:0]  force_seen, force_seen2;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ssit_clr_ctrl #(.SSIT_IDX_W(4), .LFST_IDX_W(3), .CNT_W(8), .CLR_INTERVAL(16)) dut (
        .clk(clk), .rst(rst), .retire_cnt_i(retire_cnt), .force_clr_i(force_clr),
        .clr_gnt_i(clr_gnt), .clr_req_o(clr_req), .ssit_clr_we_o(ssit_we),
        .ssit_clr_idx_o(ssit_idx), .lfst_clr_we_o(lfst_we), .lfst_clr_idx_o(lfst_idx),
        .busy_o(busy), .clr_done_o(done)
`ifdef SSIT_CLR_STAT_EN
        , .clr_count_o(clr_count), .force_seen_o(force_seen)
`endif
    );

    ssit_clr_ctrl #(.SSIT_IDX_W(4), .LFST_IDX_W(3), .CNT_W(4), .CLR_INTERVAL(15)) dut_sat (
        .clk(clk), .rst(rst), .retire_cnt_i(retire2), .force_clr_i(force2),
        .clr_gnt_i(gnt2), .clr_req_o(req2), .ssit_clr_we_o(swe2),
        .ssit_clr_idx_o(sidx2), .lfst_clr_we_o(lwe2), .lfst_clr_idx_o(lidx2),
        .busy_o(busy2), .clr_done_o(done2)
`ifdef SSIT_CLR_STAT_EN
        , .clr_count_o(clr_count2), .force_seen_o(force_seen2)
`endif
    );

    typedef struct {
        logic [2:0] retire;
        logic       force_clr;
        logic       gnt;
        logic       req;
        logic       swe;
        logic [3:0] sidx;
        logic       lwe;
        logic [2:0] lidx;
        logic       busy;
        logic       done;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[23];

    function automatic vec_t mk(input logic [2:0] r, input logic f, input logic g,
                                input logic req, input logic swe, input logic [3:0] sidx,
                                input logic lwe, input logic [2:0] lidx, input logic bsy,
                                input logic dn, input logic [7:0] cnt);
        vec_t v;
        v.retire = r; v.force_clr = f; v.gnt = g;
        v.req = req; v.swe = swe; v.sidx = sidx; v.lwe = lwe; v.lidx = lidx;
        v.busy = bsy; v.done = dn; v.cnt = cnt;
        return v;
    endfunction

    function automatic vec_t walk_vec(input logic [2:0] r, input logic f, input logic g, input int i);
        logic lw;
        lw = (i < 8);
        return mk(r, f, g, 1'b1, 1'b1, 4'(i), lw, lw ? 3'(i) : 3'd0, 1'b1, 1'b0, 8'd0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_vec(input string tag, input vec_t e);
        chk({tag, ".req"},  32'(clr_req),  32'(e.req));
        chk({tag, ".swe"},  32'(ssit_we),  32'(e.swe));
        chk({tag, ".sidx"}, 32'(ssit_idx), 32'(e.sidx));
        chk({tag, ".lwe"},  32'(lfst_we),  32'(e.lwe));
        chk({tag, ".lidx"}, 32'(lfst_idx), 32'(e.lidx));
        chk({tag, ".busy"}, 32'(busy),     32'(e.busy));
        chk({tag, ".done"}, 32'(done),     32'(e.done));
        chk({tag, ".cnt"},  32'(dut.interval_cnt), 32'(e.cnt));
    endtask

    task automatic run(input string tag, input vec_t v);
        retire_cnt = v.retire;
        force_clr  = v.force_clr;
        clr_gnt    = v.gnt;
        @(posedge clk);
        #1;
        check_vec(tag, v);
    endtask

    // Continues a walk already showing index 0 through DONE back to IDLE.
    task automatic finish_walk(input string tag, input logic [2:0] r, input int force_at);
        for (int i = 1; i < 16; i++)
            run($sformatf("%s.w%0d", tag, i), walk_vec(r, i == force_at, 1'b0, i));
        run({tag, ".done"}, mk(r, 1'b0, 1'b0, 0, 0, 0, 0, 0, 1, 1, 8'd0));
        run({tag, ".idle"}, mk(r, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 8'd0));
    endtask

    task automatic sat_step(input string tag, input logic [2:0] r, input logic exp_req,
                            input logic [3:0] exp_cnt);
        retire2 = r;
        @(posedge clk);
        #1;
        chk({tag, ".req"}, 32'(req2), 32'(exp_req));
        chk({tag, ".cnt"}, 32'(dut_sat.interval_cnt), 32'(exp_cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; retire_cnt = '0; force_clr = 1'b0; clr_gnt = 1'b0;
        retire2 = '0; force2 = 1'b0; gnt2 = 1'b0;

        for (int i = 0; i < 4; i++)
            tbl[i] = mk(3'd4, 1'b0, 1'b0, i == 3, 0, 0, 0, 0, i == 3, 0, 8'(4 * (i + 1)));
        for (int i = 0; i < 16; i++)
            tbl[4 + i] = walk_vec(3'd0, 1'b0, 1'b1, i);
        tbl[20] = mk(3'd0, 1'b0, 1'b1, 0, 0, 0, 0, 0, 1, 1, 8'd0);
        tbl[21] = mk(3'd0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 8'd0);
        tbl[22] = mk(3'd0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 8'd0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_vec("reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd0));
        chk("reset.req2", 32'(req2), 32'd0);
        chk("reset.busy2", 32'(busy2), 32'd0);
        rst = 1'b0;

        // Interval-triggered clear with immediate grant
        for (int i = 0; i < 23; i++)
            run($sformatf("basic[%0d]", i), tbl[i]);
`ifdef SSIT_CLR_STAT_EN
        chk("stat1.count", 32'(clr_count), 32'd1);
        chk("stat1.fseen", 32'(force_seen), 32'd0);
`endif

        // Grant held off for 10 cycles while retirements continue
        for (int i = 0; i < 4; i++)
            run("gd.fill", mk(3'd4, 0, 0, i == 3, 0, 0, 0, 0, i == 3, 0, 8'(4 * (i + 1))));
        for (int i = 0; i < 10; i++)
            run($sformatf("gd.wait%0d", i), mk(3'd2, 0, 0, 1, 0, 0, 0, 0, 1, 0, 8'd16));
        run("gd.w0", walk_vec(3'd2, 1'b0, 1'b1, 0));
        finish_walk("gd", 3'd2, -1);
        run("gd.post", mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd0));

        // Forced clear at counter 5; a force pulse mid-walk must not queue
        run("fc.c4", mk(3'd4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd4));
        run("fc.c5", mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd5));
        run("fc.req", mk(3'd0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 8'd5));
        run("fc.w0", walk_vec(3'd0, 1'b0, 1'b1, 0));
        finish_walk("fc", 3'd0, 3);
        for (int i = 0; i < 3; i++)
            run($sformatf("fc.quiet%0d", i), mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd0));
`ifdef SSIT_CLR_STAT_EN
        chk("stat3.count", 32'(clr_count), 32'd3);
        chk("stat3.fseen", 32'(force_seen), 32'd1);
`endif

        // Saturating counter on the narrow instance
        sat_step("sat.a", 3'd4, 1'b0, 4'd4);
        sat_step("sat.b", 3'd4, 1'b0, 4'd8);
        sat_step("sat.c", 3'd4, 1'b0, 4'd12);
        sat_step("sat.d", 3'd2, 1'b0, 4'd14);
        sat_step("sat.e", 3'd4, 1'b1, 4'd15);
        retire2 = '0;

        // Reset in the middle of a walk
        run("rw.req", mk(3'd0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 8'd0));
        run("rw.w0", walk_vec(3'd0, 1'b0, 1'b1, 0));
        for (int i = 1; i <= 6; i++)
            run($sformatf("rw.w%0d", i), walk_vec(3'd0, 1'b0, 1'b0, i));
        rst = 1'b1;
        run("rw.rst", mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd0));
        rst = 1'b0;
        for (int i = 0; i < 3; i++)
            run($sformatf("rw.after%0d", i), mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd0));
`ifdef SSIT_CLR_STAT_EN
        chk("statr.count", 32'(clr_count), 32'd0);
`endif
        run("rw.req2", mk(3'd0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 8'd0));
        run("rw.restart", walk_vec(3'd0, 1'b0, 1'b1, 0));
        finish_walk("rw2", 3'd0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
